// File: rtl/uart_rx_fifo_writer.sv
// UART 8N1 receiver that pushes each good byte into an async FIFO write port.
// Define UART_PARITY_EN to add one even-parity bit between the data and stop bits.
module uart_rx_fifo_writer #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_w,
    input  logic                  rst_n_w,
    input  logic                  i_rx,
    input  logic                  i_full,
    input  logic                  i_clr_err,
    output logic                  o_wr_en,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_busy,
    output logic                  o_frame_err,
    output logic                  o_overflow,
    output logic                  o_parity_err,
    output logic [15:0]           o_byte_cnt
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    state_t                r_state_reg, w_state_next;
    logic                  r_sync1, r_rx_s;
    logic [TW-1:0]         r_timer_reg, w_timer_next;
    logic [BW-1:0]         r_idx_reg, w_idx_next;
    logic [DATA_WIDTH-1:0] r_shift_reg, w_shift_next;
    logic                  w_push, w_set_frame, w_set_ovf;
    logic                  r_push_reg, r_wr_en_reg;
    logic [DATA_WIDTH-1:0] r_wr_data_reg;
    logic [15:0]           r_byte_cnt_reg;
    logic                  r_frame_err_reg, r_overflow_reg;
`ifdef UART_PARITY_EN
    logic                  r_par_bad_reg, w_par_bad_next, w_set_par, r_parity_err_reg;
`endif

    always_ff @(posedge clk_w or negedge rst_n_w) begin
        if (!rst_n_w) begin
            r_state_reg <= ST_IDLE;
        end else begin
            r_state_reg <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state_reg;
        w_timer_next = r_timer_reg;
        w_idx_next   = r_idx_reg;
        w_shift_next = r_shift_reg;
        w_push       = 1'b0;
        w_set_frame  = 1'b0;
        w_set_ovf    = 1'b0;
`ifdef UART_PARITY_EN
        w_par_bad_next = r_par_bad_reg;
        w_set_par      = 1'b0;
`endif
        case (r_state_reg)
            ST_IDLE: begin
                if (!r_rx_s) begin
                    w_state_next = ST_START;
                    w_timer_next = '0;
                end
            end
            ST_START: begin
                if (r_timer_reg == HALF_LAST) begin
                    w_timer_next = '0;
                    w_idx_next   = '0;
                    w_state_next = r_rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    w_timer_next = r_timer_reg + 1'b1;
                end
            end
            ST_DATA: begin
                if (r_timer_reg == BIT_LAST) begin
                    w_timer_next = '0;
                    w_shift_next = {r_rx_s, r_shift_reg[DATA_WIDTH-1:1]};
                    w_idx_next   = r_idx_reg + 1'b1;
                    if (r_idx_reg == IDX_LAST) begin
`ifdef UART_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next = ST_STOP;
`endif
                    end
                end else begin
                    w_timer_next = r_timer_reg + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (r_timer_reg == BIT_LAST) begin
                    w_timer_next   = '0;
                    w_par_bad_next = ^{r_shift_reg, r_rx_s};
                    w_state_next   = ST_STOP;
                end else begin
                    w_timer_next = r_timer_reg + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (r_timer_reg == BIT_LAST) begin
                    w_timer_next = '0;
                    // A low stop bit masks every other outcome of the frame.
                    if (!r_rx_s) begin
                        w_set_frame  = 1'b1;
                        w_state_next = ST_BREAK;
                    end else begin
                        w_state_next = ST_IDLE;
`ifdef UART_PARITY_EN
                        if (r_par_bad_reg) w_set_par = 1'b1;
                        else
`endif
                        if (i_full) w_set_ovf = 1'b1;
                        else        w_push    = 1'b1;
                    end
                end else begin
                    w_timer_next = r_timer_reg + 1'b1;
                end
            end
            ST_BREAK: begin
                if (r_rx_s) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_w or negedge rst_n_w) begin
        if (!rst_n_w) begin
            r_sync1         <= 1'b1;
            r_rx_s          <= 1'b1;
            r_timer_reg     <= '0;
            r_idx_reg       <= '0;
            r_shift_reg     <= '0;
            r_push_reg      <= 1'b0;
            r_wr_en_reg     <= 1'b0;
            r_wr_data_reg   <= '0;
            r_byte_cnt_reg  <= '0;
            r_frame_err_reg <= 1'b0;
            r_overflow_reg  <= 1'b0;
        end else begin
            r_sync1     <= i_rx;
            r_rx_s      <= r_sync1;
            r_timer_reg <= w_timer_next;
            r_idx_reg   <= w_idx_next;
            r_shift_reg <= w_shift_next;
            // Decision registered first, strobe one cycle later.
            r_push_reg  <= w_push;
            r_wr_en_reg <= r_push_reg;
            if (r_push_reg) begin
                r_wr_data_reg  <= r_shift_reg;
                r_byte_cnt_reg <= r_byte_cnt_reg + 16'd1;
            end
            if (w_set_frame)    r_frame_err_reg <= 1'b1;
            else if (i_clr_err) r_frame_err_reg <= 1'b0;
            if (w_set_ovf)      r_overflow_reg  <= 1'b1;
            else if (i_clr_err) r_overflow_reg  <= 1'b0;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk_w or negedge rst_n_w) begin
        if (!rst_n_w) begin
            r_par_bad_reg    <= 1'b0;
            r_parity_err_reg <= 1'b0;
        end else begin
            r_par_bad_reg <= w_par_bad_next;
            if (w_set_par)      r_parity_err_reg <= 1'b1;
            else if (i_clr_err) r_parity_err_reg <= 1'b0;
        end
    end
    assign o_parity_err = r_parity_err_reg;
`else
    assign o_parity_err = 1'b0;
`endif

    assign o_wr_en     = r_wr_en_reg;
    assign o_wr_data   = r_wr_data_reg;
    assign o_busy      = (r_state_reg != ST_IDLE);
    assign o_frame_err = r_frame_err_reg;
    assign o_overflow  = r_overflow_reg;
    assign o_byte_cnt  = r_byte_cnt_reg;
endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// Self-checking bench for uart_rx_fifo_writer: a serial line driver plus a
// frame-level model of which bytes must reach the FIFO and which flags must set.
`timescale 1ns/1ps
module tb_uart_rx_fifo_writer;
    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int DW     = 8;

    logic          clk_w = 1'b0;
    logic          rst_n_w = 1'b0;
    logic          rx = 1'b1;
    logic          full = 1'b0;
    logic          clr_err = 1'b0;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          busy, frame_err, overflow, parity_err;
    logic [15:0]   byte_cnt;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_q[$];
    int            exp_cnt = 0;
    logic          prev_wr_en = 1'b0;

    always #5 clk_w = ~clk_w;

    uart_rx_fifo_writer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_WIDTH(DW)) dut (
        .clk_w(clk_w), .rst_n_w(rst_n_w), .i_rx(rx), .i_full(full), .i_clr_err(clr_err),
        .o_wr_en(wr_en), .o_wr_data(wr_data), .o_busy(busy), .o_frame_err(frame_err),
        .o_overflow(overflow), .o_parity_err(parity_err), .o_byte_cnt(byte_cnt)
    );

    // Collect every FIFO write and check the strobe is a single-cycle pulse.
    always @(negedge clk_w) begin
        if (wr_en === 1'b1) begin
            got_q.push_back(wr_data);
            checks++;
            if (prev_wr_en === 1'b1) begin
                errors++;
                $display("FAIL wr_en_pulse: wr_en high on consecutive cycles, got 1 required 0");
            end
        end
        prev_wr_en = wr_en;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_w);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(CPB);
    endtask

    task automatic send_head(input logic [DW-1:0] d);
        send_bit(1'b0);
        for (int i = 0; i < DW; i++) send_bit(d[i]);
    endtask

    // Well-formed parity (when present); stop level chosen by the caller.
    task automatic send_frame(input logic [DW-1:0] d, input logic stop_b);
        send_head(d);
`ifdef UART_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop_b);
    endtask

    task automatic pulse_clr;
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        tick(1);
    endtask

    task automatic check_writes(input string name);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d writes, required %0d", name, got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s_data[%0d]: got 0x%02h required 0x%02h", name, i, got_q[i], exp_q[i]);
                end
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset;
        rst_n_w = 1'b0;
        tick(3);
        checks++;
        if ({wr_en, wr_data, busy, frame_err, overflow, parity_err, byte_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_values: got wr_en=%b wr_data=%02h busy=%b fe=%b ov=%b pe=%b cnt=%0d required all 0",
                     wr_en, wr_data, busy, frame_err, overflow, parity_err, byte_cnt);
        end
        rst_n_w = 1'b1;
        tick(5);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_single;
        exp_q.push_back(8'hA5);
        exp_cnt++;
        send_frame(8'hA5, 1'b1);
        check_writes("single");
        checks++;
        if (byte_cnt !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL single_cnt: got %0d required %0d", byte_cnt, exp_cnt);
        end
        checks++;
        if ({busy, frame_err, overflow, parity_err} !== 4'b0) begin
            errors++;
            $display("FAIL single_status: got busy/fe/ov/pe=%b required 0000", {busy, frame_err, overflow, parity_err});
        end
        tick(3 * CPB);
        checks++;
        if (wr_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_hold: got wr_data 0x%02h required 0xA5", wr_data);
        end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] vals [3];
        vals = '{8'h00, 8'hFF, 8'h55};
        foreach (vals[i]) begin
            exp_q.push_back(vals[i]);
            exp_cnt++;
            send_frame(vals[i], 1'b1);
        end
        check_writes("b2b");
        checks++;
        if (byte_cnt !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL b2b_cnt: got %0d required %0d", byte_cnt, exp_cnt);
        end
    endtask

    task automatic test_overflow;
        full = 1'b1;
        send_frame(8'h3C, 1'b1);
        full = 1'b0;
        tick(2);
        check_writes("ovf");
        checks++;
        if (overflow !== 1'b1 || byte_cnt !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL ovf_set: got overflow=%b cnt=%0d required 1 and %0d", overflow, byte_cnt, exp_cnt);
        end
        pulse_clr();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b required 0", overflow);
        end
    endtask

    task automatic test_break;
        send_frame(8'h12, 1'b0);
        rx = 1'b0;
        tick(30 * CPB);
        checks++;
        if (frame_err !== 1'b1 || busy !== 1'b1 || got_q.size() != 0) begin
            errors++;
            $display("FAIL break_hold: got fe=%b busy=%b writes=%0d required 1 1 0", frame_err, busy, got_q.size());
        end
        rx = 1'b1;
        tick(2 * CPB);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL break_exit: got busy %b required 0", busy);
        end
        exp_q.push_back(8'h34);
        exp_cnt++;
        send_frame(8'h34, 1'b1);
        check_writes("break_next");
        checks++;
        if (frame_err !== 1'b1 || byte_cnt !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL break_sticky: got fe=%b cnt=%0d required 1 and %0d", frame_err, byte_cnt, exp_cnt);
        end
        pulse_clr();
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL break_clear: got %b required 0", frame_err);
        end
    endtask

    task automatic test_glitch_and_reset;
        logic [DW-1:0] d;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(2 * CPB);
        check_writes("glitch");
        checks++;
        if ({busy, frame_err, overflow, parity_err} !== 4'b0) begin
            errors++;
            $display("FAIL glitch_status: got busy/fe/ov/pe=%b required 0000", {busy, frame_err, overflow, parity_err});
        end
        d = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx = d[4];
        tick(CPB / 2);
        rst_n_w = 1'b0;
        rx = 1'b1;
        exp_cnt = 0;
        tick(3);
        checks++;
        if (busy !== 1'b0 || byte_cnt !== 16'd0 || wr_data !== 8'h00) begin
            errors++;
            $display("FAIL midreset: got busy=%b cnt=%0d wr_data=%02h required 0 0 00", busy, byte_cnt, wr_data);
        end
        rst_n_w = 1'b1;
        tick(2 * CPB);
        exp_q.push_back(8'h81);
        exp_cnt++;
        send_frame(8'h81, 1'b1);
        check_writes("post_reset");
        checks++;
        if (byte_cnt !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL post_reset_cnt: got %0d required %0d", byte_cnt, exp_cnt);
        end
    endtask

    task automatic test_random;
        logic          exp_ovf;
        logic [DW-1:0] d;
        logic          f;
        exp_ovf = 1'b0;
        for (int n = 0; n < 12; n++) begin
            d = DW'($urandom_range(0, 255));
            f = ($urandom_range(0, 3) == 0);
            full = f;
            if (f) exp_ovf = 1'b1;
            else begin
                exp_q.push_back(d);
                exp_cnt++;
            end
            send_frame(d, 1'b1);
            full = 1'b0;
            tick($urandom_range(0, 2) * CPB);
        end
        tick(2);
        check_writes("random");
        checks++;
        if (byte_cnt !== 16'(exp_cnt) || overflow !== exp_ovf || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL random_status: got cnt=%0d ov=%b fe=%b required %0d %b 0",
                     byte_cnt, overflow, frame_err, exp_cnt, exp_ovf);
        end
        pulse_clr();
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity;
        exp_q.push_back(8'h07);
        exp_cnt++;
        send_head(8'h07);
        send_bit(1'b1);
        send_bit(1'b1);
        send_head(8'h07);
        send_bit(1'b0);
        send_bit(1'b1);
        tick(2);
        check_writes("parity");
        checks++;
        if (parity_err !== 1'b1 || byte_cnt !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL parity_flag: got pe=%b cnt=%0d required 1 and %0d", parity_err, byte_cnt, exp_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_break();
        test_glitch_and_reset();
        test_random();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
